// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word/register types plus rf_write_arbiter grant encoding and defaults
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0] regbits_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_REQ0, GNT_REQ1} rfarb_gnt_t;
    localparam int unsigned RFARB_STARVE_DEFAULT = 4;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: two writer request channels and the registered register-file write port
interface rf_write_arbiter_if;
    import cpu_types_pkg::*;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    regbits_t req0_wsel, req1_wsel, rf_wsel;
    word_t req0_wdat, req1_wdat, rf_wdat;
    logic rf_WEN, force_gnt;
    modport slave (
        input req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        output req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat, force_gnt
    );
    modport master (
        output req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        input req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat, force_gnt
    );
endinterface

// File: rtl/rf_arb_stats.sv
// rf_arb_stats: saturating conflict and forced-grant counters, built only with RF_ARB_STATS_EN
module rf_arb_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  conflict,
    input  logic  forced,
    output word_t stat_conflicts,
    output word_t stat_forced
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (conflict && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 32'd1;
            if (forced && stat_forced != '1) stat_forced <= stat_forced + 32'd1;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: fixed-priority RF write port sharing with req1 starvation guard; RF_ARB_STATS_EN adds stat counters
module rf_write_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = RFARB_STARVE_DEFAULT
) (
    input logic CLK,
    input logic nRST,
    rf_write_arbiter_if.slave bus
`ifdef RF_ARB_STATS_EN
    ,
    output word_t stat_conflicts,
    output word_t stat_forced
`endif
);
    logic [7:0] starve_cnt, starve_next;
    rfarb_gnt_t gnt;
    logic forced;
    regbits_t win_sel;
    word_t win_dat;
    always_comb begin
        forced = bus.req1_valid && starve_cnt == 8'(STARVE_LIMIT);
        gnt = forced ? GNT_REQ1 : bus.req0_valid ? GNT_REQ0 : bus.req1_valid ? GNT_REQ1 : GNT_NONE;
        win_sel = gnt == GNT_REQ1 ? bus.req1_wsel : bus.req0_wsel;
        win_dat = gnt == GNT_REQ1 ? bus.req1_wdat : bus.req0_wdat;
        starve_next = (!bus.req1_valid || gnt == GNT_REQ1) ? 8'd0 :
                      starve_cnt == 8'hFF ? starve_cnt : starve_cnt + 8'd1;
    end
    assign bus.req0_ready = gnt == GNT_REQ0;
    assign bus.req1_ready = gnt == GNT_REQ1;
    // r0 writes are granted and consume the slot but never assert WEN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt    <= '0;
            bus.rf_WEN    <= 1'b0;
            bus.rf_wsel   <= '0;
            bus.rf_wdat   <= '0;
            bus.force_gnt <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            bus.rf_WEN <= gnt != GNT_NONE && win_sel != '0;
            if (gnt != GNT_NONE) begin
                bus.rf_wsel   <= win_sel;
                bus.rf_wdat   <= win_dat;
                bus.force_gnt <= forced;
            end
        end
    end
`ifdef RF_ARB_STATS_EN
    rf_arb_stats u_stats (
        .CLK(CLK),
        .nRST(nRST),
        .conflict(bus.req0_valid && bus.req1_valid),
        .forced(forced),
        .stat_conflicts(stat_conflicts),
        .stat_forced(stat_forced)
    );
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of grant priority, starvation guard, output stage and reset
module tb_rf_write_arbiter;
    import cpu_types_pkg::*;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int passed = 0;
    int total = 0;
    rf_write_arbiter_if bus ();
`ifdef RF_ARB_STATS_EN
    word_t stat_conflicts, stat_forced;
`endif
    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_conflicts(stat_conflicts),
        .stat_forced(stat_forced)
`endif
    );
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_wsel = '0; bus.req0_wdat = '0;
        bus.req1_valid = 0; bus.req1_wsel = '0; bus.req1_wdat = '0;
        tick(); tick();
        chk("rst_wen", bus.rf_WEN, 0);
        chk("rst_wsel", bus.rf_wsel, 0);
        chk("rst_wdat", bus.rf_wdat, 0);
        chk("rst_force", bus.force_gnt, 0);
        nRST = 1;
        // req0 alone
        bus.req0_valid = 1; bus.req0_wsel = 5'd3; bus.req0_wdat = 32'hDEADBEEF;
        #1;
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        chk("t1_wen", bus.rf_WEN, 1);
        chk("t1_wsel", bus.rf_wsel, 3);
        chk("t1_wdat", bus.rf_wdat, 32'hDEADBEEF);
        tick();
        chk("idle_wen", bus.rf_WEN, 0);
        chk("idle_hold_wsel", bus.rf_wsel, 3);
        chk("idle_hold_wdat", bus.rf_wdat, 32'hDEADBEEF);
        // req1 alone to r0: granted but suppressed
        bus.req1_valid = 1; bus.req1_wsel = 5'd0; bus.req1_wdat = 32'h1234;
        #1;
        chk("t3_ready1", bus.req1_ready, 1);
        chk("t3_ready0", bus.req0_ready, 0);
        tick();
        bus.req1_valid = 0;
        chk("t3_wen", bus.rf_WEN, 0);
        chk("t3_wdat", bus.rf_wdat, 32'h1234);
        chk("t3_force", bus.force_gnt, 0);
        // continuous conflict: 4 req0 grants then one forced req1 grant, twice
        bus.req0_valid = 1; bus.req0_wsel = 5'd1; bus.req0_wdat = 32'hA0;
        bus.req1_valid = 1; bus.req1_wsel = 5'd2; bus.req1_wdat = 32'hB1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("t2_ready0_%0d", k), bus.req0_ready, k % 5 != 4);
            chk($sformatf("t2_ready1_%0d", k), bus.req1_ready, k % 5 == 4);
            tick();
            chk($sformatf("t2_wsel_%0d", k), bus.rf_wsel, k % 5 == 4 ? 2 : 1);
            chk($sformatf("t2_force_%0d", k), bus.force_gnt, k % 5 == 4);
        end
`ifdef RF_ARB_STATS_EN
        chk("stat_conflicts", stat_conflicts, 10);
        chk("stat_forced", stat_forced, 2);
`endif
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        // same destination from both writers: grant order defines final value
        bus.req0_valid = 1; bus.req0_wsel = 5'd7; bus.req0_wdat = 32'h11;
        bus.req1_valid = 1; bus.req1_wsel = 5'd7; bus.req1_wdat = 32'h22;
        #1;
        chk("t4_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 0;
        chk("t4_wdat_first", bus.rf_wdat, 32'h11);
        chk("t4_wen_first", bus.rf_WEN, 1);
        #1;
        chk("t4_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        chk("t4_wdat_last", bus.rf_wdat, 32'h22);
        chk("t4_wsel_last", bus.rf_wsel, 7);
        chk("t4_wen_last", bus.rf_WEN, 1);
        // reset mid-burst after starve_cnt has reached 3
        bus.req0_valid = 1; bus.req0_wsel = 5'd4; bus.req0_wdat = 32'h44;
        bus.req1_valid = 1; bus.req1_wsel = 5'd5; bus.req1_wdat = 32'h55;
        tick(); tick(); tick();
        chk("t5_pre_wen", bus.rf_WEN, 1);
        #2;
        nRST = 0;
        #1;
        chk("t5_async_wen", bus.rf_WEN, 0);
        chk("t5_async_wsel", bus.rf_wsel, 0);
        chk("t5_async_wdat", bus.rf_wdat, 0);
        chk("t5_rst_ready0", bus.req0_ready, 1);
        chk("t5_rst_ready1", bus.req1_ready, 0);
`ifdef RF_ARB_STATS_EN
        chk("t5_stat_clr", stat_conflicts, 0);
`endif
        tick();
        chk("t5_hold_wen", bus.rf_WEN, 0);
        nRST = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t5_ready0_%0d", k), bus.req0_ready, k != 4);
            chk($sformatf("t5_ready1_%0d", k), bus.req1_ready, k == 4);
            tick();
            chk($sformatf("t5_wsel_%0d", k), bus.rf_wsel, k == 4 ? 5 : 4);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        chk("end_wen", bus.rf_WEN, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
